// File: rtl/sram_banked_mc.sv
// sram_banked_mc
// Multi-channel banked scratchpad. A request carries up to MAX_CHANNELS
// addresses. Each bank serves one channel per cycle, so channels that
// collide in a bank are serialised. All channels are returned together
// as one response.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o request handshake
//   req_we_i                1 = write all active lanes, 0 = read
//   req_num_channels_i      number of active lanes (clamped to MAX_CHANNELS)
//   req_addr_i, req_data_i  packed per-lane address / write data
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_data_o              packed per-lane read data (0 for writes)
//   busy_o                  request in flight
//   conflict_cycles_o       saturating count of extra issue cycles
module sram_banked_mc #(
  parameter int DATA_WIDTH         = 8,
  parameter int N_ENTRIES          = 4096,
  parameter int N_BANKS            = 8,
  parameter int MAX_CHANNELS       = 8,
  parameter int ADDRW              = $clog2(N_ENTRIES),
  parameter int BANKW              = $clog2(N_BANKS),
  parameter int NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic                               req_we_i,
  input  logic [NUM_CHANNELS_WIDTH-1:0]      req_num_channels_i,
  input  logic [ADDRW*MAX_CHANNELS-1:0]      req_addr_i,
  input  logic [DATA_WIDTH*MAX_CHANNELS-1:0] req_data_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic [DATA_WIDTH*MAX_CHANNELS-1:0] rsp_data_o,
  output logic                               busy_o,
  output logic [15:0]                        conflict_cycles_o
);

  localparam int ROWW = ADDRW - BANKW;
  localparam int ROWS = N_ENTRIES / N_BANKS;
  localparam logic [NUM_CHANNELS_WIDTH-1:0] MAX_CH_N = NUM_CHANNELS_WIDTH'(MAX_CHANNELS);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                            state_q, state_d;
  logic                              we_q, we_d;
  logic [ADDRW*MAX_CHANNELS-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH*MAX_CHANNELS-1:0] wdata_q, wdata_d;
  logic [MAX_CHANNELS-1:0]           mask_q, mask_d;
  logic [DATA_WIDTH*MAX_CHANNELS-1:0] result_q, result_d;
  logic [15:0]                       conflict_cycles_q, conflict_cycles_d;
  logic                              first_q, first_d;

  // Per-cycle arbitration results
  logic [MAX_CHANNELS-1:0]           grant;
  logic [N_BANKS-1:0]                bank_taken;
  logic [BANKW-1:0]                  lane_bank;
  logic [N_BANKS-1:0]                bank_en;
  logic [N_BANKS-1:0][ROWW-1:0]      bank_row;
  logic [N_BANKS-1:0][DATA_WIDTH-1:0] bank_wdata;
  logic [N_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;
  logic [NUM_CHANNELS_WIDTH-1:0]     n_clamped;

  // Walking lanes in ascending order gives each bank its lowest pending
  // lane; this is what makes duplicate writes resolve highest-lane-last.
  always_comb begin
    grant      = '0;
    bank_taken = '0;
    lane_bank  = '0;
    bank_en    = '0;
    bank_row   = '0;
    bank_wdata = '0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      lane_bank = addr_q[ADDRW*i +: BANKW];
      if (mask_q[i] && !bank_taken[lane_bank]) begin
        grant[i]              = 1'b1;
        bank_taken[lane_bank] = 1'b1;
        bank_en[lane_bank]    = 1'b1;
        bank_row[lane_bank]   = addr_q[ADDRW*i + BANKW +: ROWW];
        bank_wdata[lane_bank] = wdata_q[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  // One single-port array per bank; contents are never reset.
  for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [ROWS];
    always_ff @(posedge clk_i) begin
      if (state_q == ISSUE && we_q && bank_en[gi]) begin
        mem[bank_row[gi]] <= bank_wdata[gi];
      end
    end
    assign bank_rdata[gi] = mem[bank_row[gi]];
  end

  always_comb begin
    state_d           = state_q;
    we_d              = we_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    mask_d            = mask_q;
    result_d          = result_q;
    conflict_cycles_d = conflict_cycles_q;
    first_d           = first_q;
    n_clamped         = (req_num_channels_i > MAX_CH_N) ? MAX_CH_N : req_num_channels_i;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d     = req_we_i;
          addr_d   = req_addr_i;
          wdata_d  = req_data_i;
          result_d = '0;
          first_d  = 1'b1;
          mask_d   = '0;
          for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (NUM_CHANNELS_WIDTH'(i) < n_clamped) mask_d[i] = 1'b1;
          end
          state_d = (n_clamped == '0) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mask_d  = mask_q & ~grant;
        first_d = 1'b0;
        if (!first_q && conflict_cycles_q != 16'hFFFF) begin
          conflict_cycles_d = conflict_cycles_q + 16'd1;
        end
        if (!we_q) begin
          for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (grant[i]) begin
              result_d[DATA_WIDTH*i +: DATA_WIDTH] = bank_rdata[addr_q[ADDRW*i +: BANKW]];
            end
          end
        end
        if (mask_d == '0) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= IDLE;
      we_q              <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      mask_q            <= '0;
      result_q          <= '0;
      conflict_cycles_q <= '0;
      first_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      we_q              <= we_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      mask_q            <= mask_d;
      result_q          <= result_d;
      conflict_cycles_q <= conflict_cycles_d;
      first_q           <= first_d;
    end
  end

  assign req_ready_o       = (state_q == IDLE);
  assign rsp_valid_o       = (state_q == RESP);
  assign rsp_data_o        = result_q;
  assign busy_o            = (state_q != IDLE);
  assign conflict_cycles_o = conflict_cycles_q;

endmodule

// File: tb/tb_sram_banked_mc.sv
// Testbench for sram_banked_mc: scoreboard of expected response data and
// latency, a reference memory model, and a conflict-counter model.
module tb_sram_banked_mc;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [3:0]  req_num_channels_i = '0;
  logic [95:0] req_addr_i = '0;
  logic [63:0] req_data_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [63:0] rsp_data_o;
  logic        busy_o;
  logic [15:0] conflict_cycles_o;

  sram_banked_mc dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_we_i           (req_we_i),
    .req_num_channels_i (req_num_channels_i),
    .req_addr_i         (req_addr_i),
    .req_data_i         (req_data_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_data_o         (rsp_data_o),
    .busy_o             (busy_o),
    .conflict_cycles_o  (conflict_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  logic [7:0]  model_mem [4096];
  logic [15:0] exp_cnt = '0;
  logic [63:0] exp_data_q [$];
  int          exp_lat_q [$];
  int          req_a [8];
  int          req_d [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one request, compare its response against the scoreboard, then
  // hold rsp_ready_i low for 'hold' cycles before taking it.
  task automatic run_req(input logic we, input int n, input int hold);
    int          nc, k, c;
    int          cnt [8];
    logic [63:0] exp_data, got_data;
    int          exp_lat;
    nc = (n > 8) ? 8 : n;
    k = 0;
    for (int b = 0; b < 8; b++) cnt[b] = 0;
    exp_data = '0;
    for (int i = 0; i < nc; i++) begin
      cnt[req_a[i] % 8]++;
      if (cnt[req_a[i] % 8] > k) k = cnt[req_a[i] % 8];
      if (we) model_mem[req_a[i]] = 8'(req_d[i]);
      else    exp_data[8*i +: 8] = model_mem[req_a[i]];
    end
    if (k > 1) exp_cnt = (32'(exp_cnt) + k - 1 > 32'hFFFF) ? 16'hFFFF : 16'(32'(exp_cnt) + k - 1);
    exp_data_q.push_back(exp_data);
    exp_lat_q.push_back((nc == 0) ? 1 : k + 1);

    check("req_ready_idle", {63'd0, req_ready_o}, 64'd1);
    req_valid_i = 1'b1;
    req_we_i = we;
    req_num_channels_i = 4'(n);
    for (int i = 0; i < 8; i++) begin
      req_addr_i[12*i +: 12] = 12'(req_a[i]);
      req_data_i[8*i +: 8]   = 8'(req_d[i]);
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check("busy_in_flight", {63'd0, busy_o}, 64'd1);
    c = 1;
    while (!rsp_valid_o && c < 50) begin
      @(posedge clk_i); #1;
      c++;
    end
    exp_data = exp_data_q.pop_front();
    exp_lat  = exp_lat_q.pop_front();
    if (!rsp_valid_o) begin
      check("rsp_timeout", {63'd0, rsp_valid_o}, 64'd1);
      return;
    end
    check("rsp_latency", 64'(c), 64'(exp_lat));
    check("rsp_data", rsp_data_o, exp_data);
    got_data = rsp_data_o;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_i); #1;
      check("hold_valid", {63'd0, rsp_valid_o}, 64'd1);
      check("hold_data", rsp_data_o, exp_data);
      check("hold_req_ready", {63'd0, req_ready_o}, 64'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    check("ready_after_take", {63'd0, req_ready_o}, 64'd1);
    check("valid_after_take", {63'd0, rsp_valid_o}, 64'd0);
    check("conflict_cnt", {48'd0, conflict_cycles_o}, {48'd0, exp_cnt});
    $display("txn we=%0d n=%0d k=%0d lat=%0d data=%h cnt=%h", we, n, k, c, got_data, conflict_cycles_o);
  endtask

  initial begin
    // Reset state while rst_i is held from time 0
    #2;
    check("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
    check("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    check("rst_rsp_data", rsp_data_o, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_cnt", {48'd0, conflict_cycles_o}, 64'd0);
    #10 rst_i = 1'b0;
    @(posedge clk_i); #1;

    // No-conflict round trip
    req_a = '{0, 1, 2, 3, 9, 9, 9, 9};
    req_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99, 8'h99, 8'h99, 8'h99};
    run_req(1'b1, 4, 0);
    run_req(1'b0, 4, 0);

    // Full bank-0 conflict, write then read, then mixed with a bank-1 lane
    req_a = '{0, 8, 16, 24, 1, 0, 0, 0};
    req_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00};
    run_req(1'b1, 4, 0);
    run_req(1'b0, 4, 0);
    run_req(1'b0, 5, 0);

    // Duplicate-address write: highest lane wins
    req_a = '{5, 5, 0, 0, 0, 0, 0, 0};
    req_d = '{8'hAA, 8'hBB, 0, 0, 0, 0, 0, 0};
    run_req(1'b1, 2, 0);
    run_req(1'b0, 1, 0);

    // Back-pressure: response held for 3 cycles
    req_a = '{1, 2, 3, 0, 0, 0, 0, 0};
    run_req(1'b0, 3, 3);

    // Zero-channel request
    run_req(1'b0, 0, 0);

    // Over-range channel count clamps to 8
    req_a = '{100, 101, 102, 103, 104, 105, 106, 107};
    req_d = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
    run_req(1'b1, 15, 0);
    run_req(1'b0, 15, 0);

    // Random write/read-back pairs
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) begin
        req_a[i] = $urandom_range(0, 255);
        req_d[i] = $urandom_range(0, 255);
      end
      run_req(1'b1, n, 0);
      run_req(1'b0, n, 0);
    end

    // Reset mid-ISSUE: only the writes of cycles 1 and 2 land
    req_a = '{16, 24, 0, 0, 0, 0, 0, 0};
    req_d = '{8'h5A, 8'h5B, 0, 0, 0, 0, 0, 0};
    run_req(1'b1, 2, 0);
    req_a = '{0, 8, 16, 24, 0, 0, 0, 0};
    req_d = '{8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 0, 0};
    req_valid_i = 1'b1;
    req_we_i = 1'b1;
    req_num_channels_i = 4'd4;
    for (int i = 0; i < 8; i++) begin
      req_addr_i[12*i +: 12] = 12'(req_a[i]);
      req_data_i[8*i +: 8]   = 8'(req_d[i]);
    end
    @(posedge clk_i); #1;            // cycle 1
    req_valid_i = 1'b0;
    @(posedge clk_i);                // cycle 2
    @(posedge clk_i);                // cycle 3
    #2 rst_i = 1'b1;
    #1;
    check("midrst_req_ready", {63'd0, req_ready_o}, 64'd1);
    check("midrst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    check("midrst_busy", {63'd0, busy_o}, 64'd0);
    check("midrst_cnt", {48'd0, conflict_cycles_o}, 64'd0);
    model_mem[0] = 8'h01;
    model_mem[8] = 8'h02;
    exp_cnt = '0;
    @(posedge clk_i); #2 rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("no_rsp_after_rst", {63'd0, rsp_valid_o}, 64'd0);
    end
    run_req(1'b0, 4, 0);

    // Counter saturation from a preloaded 0xFFFE
    force dut.conflict_cycles_q = 16'hFFFE;
    @(posedge clk_i); #1;
    release dut.conflict_cycles_q;
    exp_cnt = 16'hFFFE;
    req_a = '{0, 8, 16, 0, 0, 0, 0, 0};
    run_req(1'b0, 3, 0);
    run_req(1'b0, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_banked_mc.md
# sram_banked_mc

Multi-channel, single-clock banked scratchpad that replaces the ideal N-channel-per-cycle memory with N_BANKS physically realisable single-access banks. A request carries up to MAX_CHANNELS independent addresses. The block serialises bank conflicts over as many cycles as needed and returns all channels together under a valid/ready handshake. It sits between the NPU datapath engines and on-chip activation/weight storage, and exports a conflict-cycle counter for performance tuning.

## Interface
- DATA_WIDTH, 8, bits per entry
- N_ENTRIES, 4096, total entries (power of 2)
- N_BANKS, 8, number of banks (power of 2, ≤ N_ENTRIES)
- MAX_CHANNELS, 8, channels per request
- ADDRW, $clog2(N_ENTRIES), entry address width
- BANKW, $clog2(N_BANKS), bank select width
- NUM_CHANNELS_WIDTH, $clog2(MAX_CHANNELS+1), channel-count width
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  block can accept a request
- req_we_i  in  1  1 = write all active channels, 0 = read
- req_num_channels_i  in  NUM_CHANNELS_WIDTH  active channels (lanes 0..n-1)
- req_addr_i  in  ADDRW*MAX_CHANNELS  per-channel address, lane i at [ADDRW*(i+1)-1 -: ADDRW]
- req_data_i  in  DATA_WIDTH*MAX_CHANNELS  per-channel write data, same packing
- rsp_valid_o  out  1  response (read data or write ack) available
- rsp_ready_i  in  1  consumer takes response
- rsp_data_o  out  DATA_WIDTH*MAX_CHANNELS  per-channel read data
- busy_o  out  1  request in flight (state ≠ IDLE)
- conflict_cycles_o  out  16  saturating count of extra issue cycles

## Operation
- Bank = addr[BANKW-1:0] (low-order interleave); row = addr[ADDRW-1:BANKW]. Each bank performs at most one read or one write per cycle.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: req_ready_o=1. On req_valid_i & req_ready_o, capture we, addr, data, and num_channels (values > MAX_CHANNELS clamp to MAX_CHANNELS). Set pending mask bit i for i < n. Clear the result register to 0. Go to ISSUE, or to RESP if n=0.
- ISSUE: per bank, serve the lowest-index pending channel mapped to it and clear that bit. Reads: result lane <= bank[row] at the cycle's edge. Writes: bank[row] <= lane data. When the mask would become empty at this edge, go to RESP.
- Duplicate addresses are serialised in ascending channel order. On writes, the highest channel wins. On reads, all duplicates return the same value.
- RESP: rsp_valid_o=1 and rsp_data_o=result register (lanes ≥ n read 0; all lanes 0 for writes). Hold until rsp_ready_i=1, then go to IDLE.
- conflict_cycles_o increments by 1 for each ISSUE cycle after the first of a request, and saturates at 0xFFFF. Only reset clears it.
- RAM contents are not reset.

## Timing
- Reset values: req_ready_o=1 (IDLE), rsp_valid_o=0, rsp_data_o=0, busy_o=0, conflict_cycles_o=0, mask=0.
- Accept in cycle 0. K = max number of active channels sharing one bank. ISSUE occupies cycles 1..K and rsp_valid_o rises in cycle K+1. For n=0, rsp_valid_o rises in cycle 1.
- Response taken in cycle R (rsp_valid_o & rsp_ready_i): req_ready_o=1 in cycle R+1. There is no same-cycle response/accept overlap.
- rsp_data_o and rsp_valid_o remain stable while rsp_ready_i=0.
- Write data is visible to a read accepted after the write's response is taken.
- Reset mid-operation: the in-flight request is dropped and no response is produced. Bank writes already performed at earlier edges persist.

## Test plan
- Reset check: assert rst_i asynchronously mid-cycle -> req_ready_o=1, rsp_valid_o=0, busy_o=0, conflict_cycles_o=0 immediately.
- No-conflict round trip: write n=4, addr 0,1,2,3, data 0x11,0x22,0x33,0x44 -> rsp_valid_o in cycle 2, counter 0. Read the same addresses -> lanes 0..3 = 0x11..0x44, lanes 4..7 = 0, rsp in cycle 2.
- Full conflict: read n=4, addr 0,8,16,24 (all bank 0) -> K=4, rsp_valid_o in cycle 5, conflict_cycles_o +3. Mix with addr 1 on lane 4 -> still K=4.
- Duplicate write: n=2, both lanes addr 5, data 0xAA (ch0), 0xBB (ch1) -> subsequent read of addr 5 returns 0xBB.
- Handshake edges: hold rsp_ready_i=0 for 3 cycles -> rsp_valid_o/rsp_data_o stable, req_ready_o=0. n=0 request -> rsp in cycle 1. n=15 (>8) -> treated as 8. Preload 0xFFFE and run two 2-conflict requests -> counter saturates at 0xFFFF.
- Reset mid-ISSUE: write addr 0,8,16,24 = 0x01..0x04, assert rst_i during cycle 3 -> no rsp_valid_o. Later reads: addr 0,8 = 0x01,0x02, addr 16,24 unchanged.
